// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types, constants and glyph table for the display scanner
package seg_pkg;

  typedef enum logic [1:0] {GAP1, DIG1, GAP2, DIG2} scan_state_t;

  // All segments dark, active-high sense
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Hex nibble to {g,f,e,d,c,b,a}, active-high
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] s;
    case (hex)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - free-running brightness PWM counter and compare
module pwm_gen #(
  parameter int PWM_W = 3
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic [PWM_W-1:0] brightness,
  output logic             pwm_on
);

  logic [PWM_W-1:0] pwm_cnt;

  // Counter wraps naturally; brightness is compared live so changes apply next cycle
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) pwm_cnt <= '0;
    else          pwm_cnt <= pwm_cnt + PWM_W'(1);
  end

  assign pwm_on = (pwm_cnt <= brightness);

endmodule

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - two-digit multiplexed seven-segment scanner with gaps, PWM and lead blanking
module seg_scan
  import seg_pkg::*;
#(
  parameter int CLK_DIV    = 1000,
  parameter int GAP_CYC    = 4,
  parameter int PWM_W      = 3,
  parameter int ACTIVE_LOW = 1
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic [3:0]       hex1,
  input  logic [3:0]       hex2,
  input  logic [PWM_W-1:0] brightness,
  input  logic             blank_lead,
  output logic [6:0]       seg,
  output logic [1:0]       digit_en
);

  localparam int MAX_LEN = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CW      = $clog2(MAX_LEN);
  localparam logic [CW-1:0] DIG_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  // XOR masks applied at the output register to get the pin polarity
  localparam logic [6:0] SEG_POL = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [1:0] EN_POL  = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

  scan_state_t   state;
  logic [CW-1:0] slot_cnt;
  logic [3:0]    snap1;
  logic [3:0]    snap2;
  logic          pwm_on;
  logic          slot_last;
  logic [6:0]    seg_nxt;
  logic [1:0]    en_nxt;

  pwm_gen #(.PWM_W(PWM_W)) u_pwm (
    .clock      (clock),
    .n_reset    (n_reset),
    .brightness (brightness),
    .pwm_on     (pwm_on)
  );

  // Slot end detection and active-high output values for the current state
  always_comb begin
    slot_last = 1'b0;
    seg_nxt   = SEG_OFF;
    en_nxt    = 2'b00;
    case (state)
      DIG1: begin
        slot_last = (slot_cnt == DIG_LAST);
        seg_nxt   = hex_to_seg(snap1);
        if (pwm_on && !(blank_lead && (snap1 == 4'h0))) en_nxt = 2'b10;
      end
      DIG2: begin
        slot_last = (slot_cnt == DIG_LAST);
        seg_nxt   = hex_to_seg(snap2);
        if (pwm_on) en_nxt = 2'b01;
      end
      default: slot_last = (slot_cnt == GAP_LAST);
    endcase
  end

  // Scan FSM, slot counter and polarity-adjusted output registers
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state    <= GAP1;
      slot_cnt <= '0;
      seg      <= SEG_OFF ^ SEG_POL;
      digit_en <= 2'b00 ^ EN_POL;
    end else begin
      seg      <= seg_nxt ^ SEG_POL;
      digit_en <= en_nxt ^ EN_POL;
      if (slot_last) begin
        slot_cnt <= '0;
        case (state)
          GAP1:    state <= DIG1;
          DIG1:    state <= GAP2;
          GAP2:    state <= DIG2;
          default: state <= GAP1;
        endcase
      end else begin
        slot_cnt <= slot_cnt + CW'(1);
      end
    end
  end

  // Nibbles are captured throughout GAP1 and frozen for the rest of the frame
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      snap1 <= 4'h0;
      snap2 <= 4'h0;
    end else if (state == GAP1) begin
      snap1 <= hex1;
      snap2 <= hex2;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - scoreboard bench for seg_scan against a frame-position reference model
module tb_seg_scan;

  localparam int CLK_DIV = 8;
  localparam int GAP     = 2;
  localparam int PWM_W   = 3;
  localparam int FRAME   = 2 * (CLK_DIV + GAP);
  localparam int HMAX    = 8192;

  logic             clock = 1'b0;
  logic             n_reset = 1'b0;
  logic [3:0]       hex1 = 4'h0;
  logic [3:0]       hex2 = 4'h0;
  logic [PWM_W-1:0] brightness = 3'd7;
  logic             blank_lead = 1'b0;
  logic [6:0]       seg;
  logic [1:0]       digit_en;

  seg_scan #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP), .PWM_W(PWM_W), .ACTIVE_LOW(1)) dut (
    .clock      (clock),
    .n_reset    (n_reset),
    .hex1       (hex1),
    .hex2       (hex2),
    .brightness (brightness),
    .blank_lead (blank_lead),
    .seg        (seg),
    .digit_en   (digit_en)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         tag;
    logic [6:0] seg;
    logic [1:0] en;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;
  int idx = 0;

  logic [3:0] h1_hist [HMAX];
  logic [3:0] h2_hist [HMAX];
  logic [2:0] br_hist [HMAX];
  logic       bl_hist [HMAX];

  // Standard hex glyphs, active-high {g,f,e,d,c,b,a}
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always @(posedge clock) begin
    if (!n_reset) edge_cnt <= 0;
    else          edge_cnt <= edge_cnt + 1;
  end

  // Pin values expected after the edge that ends cycle i (cycle 0 = first after release)
  function automatic void model(input int i, output logic [6:0] s, output logic [1:0] e);
    int f, p, samp;
    logic [3:0] d;
    logic lit;
    f = i / FRAME;
    p = i % FRAME;
    samp = f * FRAME + GAP - 1;
    lit = ((i % (1 << PWM_W)) <= int'(br_hist[i]));
    s = 7'h00;
    e = 2'b00;
    if (p >= GAP && p < GAP + CLK_DIV) begin
      d = h1_hist[samp];
      s = glyph[d];
      if (lit && !(bl_hist[i] && d == 4'h0)) e = 2'b10;
    end else if (p >= 2 * GAP + CLK_DIV) begin
      d = h2_hist[samp];
      s = glyph[d];
      if (lit) e = 2'b01;
    end
    s = ~s;
    e = ~e;
  endfunction

  task automatic cycle(input logic [3:0] a, input logic [3:0] b, input logic [2:0] br, input logic bl);
    exp_t x;
    hex1 = a;
    hex2 = b;
    brightness = br;
    blank_lead = bl;
    h1_hist[idx] = a;
    h2_hist[idx] = b;
    br_hist[idx] = br;
    bl_hist[idx] = bl;
    model(idx, x.seg, x.en);
    x.tag = idx + 1;
    q.push_back(x);
    idx++;
    @(posedge clock);
    #2;
  endtask

  task automatic check_off(input string name);
    checks++;
    if (seg !== 7'h7F || digit_en !== 2'b11) begin
      errors++;
      $display("FAIL %s: seg=%h en=%b, required seg=7f en=11", name, seg, digit_en);
    end
  endtask

  // Monitor: pops expectations as the matching edge's outputs settle, plus ghosting rules
  int last_dig = 0;
  int off_run = 0;
  always @(negedge clock) begin
    if (!n_reset) begin
      last_dig = 0;
      off_run = 0;
    end else begin
      while (q.size() > 0 && q[0].tag <= edge_cnt) begin
        exp_t x;
        x = q.pop_front();
        checks++;
        if (x.tag != edge_cnt) begin
          errors++;
          $display("FAIL missed_sample: tag=%0d at edge %0d", x.tag, edge_cnt);
        end else if (seg !== x.seg || digit_en !== x.en) begin
          errors++;
          $display("FAIL scan edge %0d: seg=%h en=%b, required seg=%h en=%b",
                   edge_cnt, seg, digit_en, x.seg, x.en);
        end
      end
      checks++;
      if (digit_en === 2'b00) begin
        errors++;
        $display("FAIL both_enables edge %0d: en=%b, required not 00", edge_cnt, digit_en);
      end
      if (digit_en === 2'b11) begin
        off_run++;
      end else begin
        int d;
        d = (digit_en === 2'b01) ? 1 : 2;
        if (last_dig != 0 && d != last_dig) begin
          checks++;
          if (off_run < GAP) begin
            errors++;
            $display("FAIL handoff_gap edge %0d: gap=%0d, required >=%0d", edge_cnt, off_run, GAP);
          end
        end
        last_dig = d;
        off_run = 0;
      end
    end
  end

  logic [3:0] ra, rb;
  logic [2:0] rbr;
  logic       rbl;

  initial begin
    // Reset held: outputs at the off level on every cycle
    repeat (4) begin
      @(negedge clock);
      check_off("reset_hold");
    end
    @(posedge clock);
    #2;
    n_reset = 1'b1;
    idx = 0;

    // Steady scan A / 1 at full brightness
    repeat (3 * FRAME) cycle(4'hA, 4'h1, 3'd7, 1'b0);

    // Tear-free: hex1 moves 3 -> 5 inside DIG2 of a frame
    for (int i = 0; i < 3 * FRAME; i++)
      cycle((i < 2 * FRAME - 3) ? 4'h3 : 4'h5, 4'h2, 3'd7, 1'b0);

    // Leading-zero blanking on then off
    repeat (2 * FRAME) cycle(4'h0, 4'h7, 3'd7, 1'b1);
    repeat (2 * FRAME) cycle(4'h0, 4'h7, 3'd7, 1'b0);

    // Brightness extremes
    repeat (2 * FRAME) cycle(4'h8, 4'hF, 3'd0, 1'b0);
    repeat (2 * FRAME) cycle(4'hB, 4'hC, 3'd3, 1'b0);

    // Random traffic with sparse input changes
    ra = 4'h0; rb = 4'h0; rbr = 3'd5; rbl = 1'b0;
    repeat (30 * FRAME) begin
      if ($urandom_range(15) == 0) ra = 4'($urandom);
      if ($urandom_range(15) == 0) rb = 4'($urandom);
      if ($urandom_range(31) == 0) rbr = 3'($urandom);
      if ($urandom_range(31) == 0) rbl = 1'($urandom);
      cycle(ra, rb, rbr, rbl);
    end

    // Asynchronous reset in the middle of a lit DIG1 slot
    while (idx % FRAME != GAP + 4) cycle(4'h8, 4'h8, 3'd7, 1'b0);
    cycle(4'h8, 4'h8, 3'd7, 1'b0);
    #1;
    n_reset = 1'b0;
    q.delete();
    #1;
    check_off("async_reset");
    repeat (2) begin
      @(negedge clock);
      check_off("reset_hold2");
    end
    @(posedge clock);
    #2;
    n_reset = 1'b1;
    idx = 0;
    repeat (4 * FRAME) begin
      if ($urandom_range(7) == 0) ra = 4'($urandom);
      if ($urandom_range(7) == 0) rb = 4'($urandom);
      if ($urandom_range(15) == 0) rbr = 3'($urandom);
      cycle(ra, rb, rbr, 1'b1);
    end

    repeat (2) @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
